rob_nway: RTL and testbench

Parametrised N-wide reorder buffer, the next generation of the single-issue ROB: a circular buffer of `DEPTH` entries. Each cycle it accepts up to `WIDTH` dispatched instructions in order, marks them complete from the CDB, and retires up to `WIDTH` completed instructions from the head in program order. It also provides two tag-indexed operand read ports for the reservation stations and flushes all in-flight state when a mispredicted instruction retires. It sits between dispatch, the CDB, the map table and the architectural register file.

---
 rtl/rob_nway.sv | 205 ++++++++++++++++++++
 tb/tb_rob_nway.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_nway.sv
// rob_nway: WIDTH-wide reorder buffer, in-order dispatch/retire with flush on a retiring mispredict.
// Optional feature macro: ROB_CDB_BYPASS_EN forwards the CDB onto the operand read ports.
module rob_nway #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2,
    parameter int XLEN  = 32,
    localparam int TW   = $clog2(DEPTH),
    localparam int FW   = $clog2(WIDTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      dp_valid,
    input  logic [WIDTH*5-1:0]    dp_dest_reg,
    input  logic [WIDTH*XLEN-1:0] dp_pc,
    output logic [WIDTH*TW-1:0]   dp_tag,
    output logic [FW-1:0]         dp_free,
    input  logic                  cdb_valid,
    input  logic [TW-1:0]         cdb_tag,
    input  logic [XLEN-1:0]       cdb_value,
    input  logic                  cdb_mispredict,
    input  logic [TW-1:0]         rd_tag_a,
    input  logic [TW-1:0]         rd_tag_b,
    output logic                  rd_ready_a,
    output logic                  rd_ready_b,
    output logic [XLEN-1:0]       rd_value_a,
    output logic [XLEN-1:0]       rd_value_b,
    output logic [WIDTH-1:0]      rt_valid,
    output logic [WIDTH*5-1:0]    rt_dest_reg,
    output logic [WIDTH*XLEN-1:0] rt_value,
    output logic [WIDTH*TW-1:0]   rt_tag,
    output logic                  flush,
    output logic [TW:0]           count
);

    logic [DEPTH-1:0] occ_q, occ_d, cmp_q, cmp_d, mis_q, mis_d;
    logic [4:0]       dest_q [DEPTH];
    logic [4:0]       dest_d [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  pc_d   [DEPTH];
    logic [XLEN-1:0]  val_q  [DEPTH];
    logic [XLEN-1:0]  val_d  [DEPTH];
    logic [TW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [TW:0]      count_q, count_d;

    logic [TW:0]      space;
    logic [FW-1:0]    free_w, n_dp, n_rt;
    logic [WIDTH-1:0] dp_take, rt_take;
    logic [TW-1:0]    dp_idx [WIDTH];
    logic [TW-1:0]    rt_idx [WIDTH];
    logic             flush_w;
    logic             unused_pc;

    // Free slots come from the pre-retire count, so a lane is taken only if it is
    // valid, below the free limit and every lower lane was taken too.
    always_comb begin
        space   = (TW+1)'(DEPTH) - count_q;
        free_w  = (space > (TW+1)'(WIDTH)) ? FW'(WIDTH) : FW'(space);
        dp_take = '0;
        n_dp    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dp_idx[i] = tail_q + TW'(i);
            if (dp_valid[i] && (FW'(i) < free_w) && (n_dp == FW'(i))) begin
                dp_take[i] = 1'b1;
                n_dp       = n_dp + FW'(1);
            end
        end
    end

    // Retire scans from head; a mispredicted entry retires but stops the scan.
    always_comb begin
        rt_take = '0;
        n_rt    = '0;
        flush_w = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            rt_idx[j] = head_q + TW'(j);
            if (!flush_w && (n_rt == FW'(j)) && occ_q[rt_idx[j]] && cmp_q[rt_idx[j]]) begin
                rt_take[j] = 1'b1;
                n_rt       = n_rt + FW'(1);
                flush_w    = mis_q[rt_idx[j]];
            end
        end
    end

    always_comb begin
        dp_free     = reset ? FW'(WIDTH) : free_w;
        rt_valid    = reset ? '0 : rt_take;
        flush       = !reset && flush_w;
        count       = count_q;
        dp_tag      = '0;
        rt_tag      = '0;
        rt_dest_reg = '0;
        rt_value    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dp_tag[i*TW +: TW]        = reset ? TW'(i) : dp_idx[i];
            rt_tag[i*TW +: TW]        = rt_idx[i];
            rt_dest_reg[i*5 +: 5]     = dest_q[rt_idx[i]];
            rt_value[i*XLEN +: XLEN]  = val_q[rt_idx[i]];
        end
    end

    always_comb begin
        rd_ready_a = occ_q[rd_tag_a] && cmp_q[rd_tag_a];
        rd_ready_b = occ_q[rd_tag_b] && cmp_q[rd_tag_b];
        rd_value_a = val_q[rd_tag_a];
        rd_value_b = val_q[rd_tag_b];
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && occ_q[cdb_tag]) begin
            if (cdb_tag == rd_tag_a) begin
                rd_ready_a = 1'b1;
                rd_value_a = cdb_value;
            end
            if (cdb_tag == rd_tag_b) begin
                rd_ready_b = 1'b1;
                rd_value_b = cdb_value;
            end
        end
`endif
        if (reset) begin
            rd_ready_a = 1'b0;
            rd_ready_b = 1'b0;
            rd_value_a = '0;
            rd_value_b = '0;
        end
    end

    // Dispatch only targets free entries and the CDB only occupied ones, so the
    // three updates never collide except CDB vs retire, where the clear wins.
    always_comb begin
        occ_d   = occ_q;
        cmp_d   = cmp_q;
        mis_d   = mis_q;
        dest_d  = dest_q;
        pc_d    = pc_q;
        val_d   = val_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_w) begin
            occ_d   = '0;
            cmp_d   = '0;
            mis_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (dp_take[i]) begin
                    occ_d[dp_idx[i]]  = 1'b1;
                    cmp_d[dp_idx[i]]  = 1'b0;
                    mis_d[dp_idx[i]]  = 1'b0;
                    dest_d[dp_idx[i]] = dp_dest_reg[i*5 +: 5];
                    pc_d[dp_idx[i]]   = dp_pc[i*XLEN +: XLEN];
                end
            end
            if (cdb_valid && occ_q[cdb_tag]) begin
                cmp_d[cdb_tag] = 1'b1;
                mis_d[cdb_tag] = cdb_mispredict;
                val_d[cdb_tag] = cdb_value;
            end
            for (int j = 0; j < WIDTH; j++) begin
                if (rt_take[j]) begin
                    occ_d[rt_idx[j]] = 1'b0;
                    cmp_d[rt_idx[j]] = 1'b0;
                    mis_d[rt_idx[j]] = 1'b0;
                end
            end
            head_d  = head_q + TW'(n_rt);
            tail_d  = tail_q + TW'(n_dp);
            count_d = count_q + (TW+1)'(n_dp) - (TW+1)'(n_rt);
        end
    end

    // The PC is held per entry for exception/debug consumers; nothing here reads it.
    always_comb begin
        unused_pc = 1'b0;
        for (int e = 0; e < DEPTH; e++) unused_pc = unused_pc ^ (^pc_q[e]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q   <= '0;
            cmp_q   <= '0;
            mis_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                dest_q[e] <= '0;
                pc_q[e]   <= '0;
                val_q[e]  <= '0;
            end
        end else begin
            occ_q   <= occ_d;
            cmp_q   <= cmp_d;
            mis_q   <= mis_d;
            dest_q  <= dest_d;
            pc_q    <= pc_d;
            val_q   <= val_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rob_nway.sv
// Randomised bench for rob_nway against a program-order queue model, plus directed scenarios.
module tb_rob_nway;
    localparam int DEPTH = 16;
    localparam int WIDTH = 2;
    localparam int XLEN  = 32;
    localparam int TW    = $clog2(DEPTH);
    localparam int FW    = $clog2(WIDTH) + 1;

    logic                  clock;
    logic                  reset;
    logic [WIDTH-1:0]      dp_valid;
    logic [WIDTH*5-1:0]    dp_dest_reg;
    logic [WIDTH*XLEN-1:0] dp_pc;
    logic [WIDTH*TW-1:0]   dp_tag;
    logic [FW-1:0]         dp_free;
    logic                  cdb_valid;
    logic [TW-1:0]         cdb_tag;
    logic [XLEN-1:0]       cdb_value;
    logic                  cdb_mispredict;
    logic [TW-1:0]         rd_tag_a, rd_tag_b;
    logic                  rd_ready_a, rd_ready_b;
    logic [XLEN-1:0]       rd_value_a, rd_value_b;
    logic [WIDTH-1:0]      rt_valid;
    logic [WIDTH*5-1:0]    rt_dest_reg;
    logic [WIDTH*XLEN-1:0] rt_value;
    logic [WIDTH*TW-1:0]   rt_tag;
    logic                  flush;
    logic [TW:0]           count;

    int checks   = 0;
    int failures = 0;

    rob_nway #(.DEPTH(DEPTH), .WIDTH(WIDTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .dp_valid(dp_valid), .dp_dest_reg(dp_dest_reg), .dp_pc(dp_pc),
        .dp_tag(dp_tag), .dp_free(dp_free),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_mispredict(cdb_mispredict),
        .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
        .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
        .rd_value_a(rd_value_a), .rd_value_b(rd_value_b),
        .rt_valid(rt_valid), .rt_dest_reg(rt_dest_reg), .rt_value(rt_value),
        .rt_tag(rt_tag), .flush(flush), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Model: in-flight instructions in program order; tail tag is head + size.
    typedef struct packed {
        logic [TW-1:0]   tag;
        logic [4:0]      dest;
        logic            done;
        logic            mis;
        logic [XLEN-1:0] val;
    } ent_t;

    ent_t mq[$];
    int   m_head = 0;

    function automatic int m_find(logic [TW-1:0] t);
        for (int i = 0; i < mq.size(); i++) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic int m_free();
        int d;
        d = DEPTH - mq.size();
        return (d < WIDTH) ? d : WIDTH;
    endfunction

    function automatic int m_nret();
        int n;
        n = 0;
        for (int j = 0; j < WIDTH; j++) begin
            if (j >= mq.size()) break;
            if (!mq[j].done) break;
            n++;
            if (mq[j].mis) break;
        end
        return n;
    endfunction

    function automatic bit m_flush();
        int n;
        n = m_nret();
        if (n == 0) return 1'b0;
        return mq[n-1].mis;
    endfunction

    task automatic rd_check(string nm, logic [TW-1:0] t, logic rdy, logic [XLEN-1:0] v);
        int p;
        logic er;
        logic [XLEN-1:0] ev;
        p  = m_find(t);
        er = 1'b0;
        ev = '0;
        if (p >= 0 && mq[p].done) begin
            er = 1'b1;
            ev = mq[p].val;
        end
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && cdb_tag == t && p >= 0) begin
            er = 1'b1;
            ev = cdb_value;
        end
`endif
        chk({nm, "_ready"}, 64'(rdy), 64'(er));
        if (er) chk({nm, "_value"}, 64'(v), 64'(ev));
    endtask

    task automatic compare();
        logic [WIDTH*TW-1:0] etag;
        int n;
        for (int i = 0; i < WIDTH; i++)
            etag[i*TW +: TW] = reset ? TW'(i) : TW'((m_head + mq.size() + i) % DEPTH);
        chk("dp_tag", 64'(dp_tag), 64'(etag));
        if (reset) begin
            chk("rst_dp_free", 64'(dp_free), 64'(WIDTH));
            chk("rst_rt_valid", 64'(rt_valid), 64'(0));
            chk("rst_flush", 64'(flush), 64'(0));
            chk("rst_rd_ready_a", 64'(rd_ready_a), 64'(0));
            chk("rst_rd_ready_b", 64'(rd_ready_b), 64'(0));
            chk("rst_rd_value_a", 64'(rd_value_a), 64'(0));
            chk("rst_rd_value_b", 64'(rd_value_b), 64'(0));
        end else begin
            n = m_nret();
            chk("count", 64'(count), 64'(mq.size()));
            chk("dp_free", 64'(dp_free), 64'(m_free()));
            chk("rt_valid", 64'(rt_valid), 64'((1 << n) - 1));
            chk("flush", 64'(flush), 64'(m_flush()));
            for (int j = 0; j < n; j++) begin
                chk("rt_tag", 64'(rt_tag[j*TW +: TW]), 64'(mq[j].tag));
                chk("rt_dest", 64'(rt_dest_reg[j*5 +: 5]), 64'(mq[j].dest));
                chk("rt_value", 64'(rt_value[j*XLEN +: XLEN]), 64'(mq[j].val));
            end
            rd_check("rd_a", rd_tag_a, rd_ready_a, rd_value_a);
            rd_check("rd_b", rd_tag_b, rd_ready_b, rd_value_b);
        end
    endtask

    // Advance the model to the state after the coming rising edge.
    task automatic m_update();
        int n, fr, base, p;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_head = 0;
        end else if (m_flush()) begin
            mq.delete();
            m_head = 0;
        end else begin
            n    = m_nret();
            fr   = m_free();
            base = m_head + mq.size();
            if (cdb_valid) begin
                p = m_find(cdb_tag);
                if (p >= 0) begin
                    e      = mq[p];
                    e.done = 1'b1;
                    e.mis  = cdb_mispredict;
                    e.val  = cdb_value;
                    mq[p]  = e;
                end
            end
            for (int j = 0; j < n; j++) void'(mq.pop_front());
            m_head = (m_head + n) % DEPTH;
            for (int i = 0; i < WIDTH; i++) begin
                if (!dp_valid[i] || i >= fr) break;
                e.tag  = TW'((base + i) % DEPTH);
                e.dest = dp_dest_reg[i*5 +: 5];
                e.done = 1'b0;
                e.mis  = 1'b0;
                e.val  = '0;
                mq.push_back(e);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            compare();
            m_update();
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        dp_valid       = '0;
        cdb_valid      = 1'b0;
        cdb_mispredict = 1'b0;
        cdb_tag        = '0;
        cdb_value      = '0;
    endtask

    task automatic disp(int k, int d0);
        for (int i = 0; i < WIDTH; i++) begin
            dp_valid[i]              = (i < k);
            dp_dest_reg[i*5 +: 5]    = 5'((d0 + i) % 32);
            dp_pc[i*XLEN +: XLEN]    = $urandom;
        end
    endtask

    task automatic cdb(int t, logic [XLEN-1:0] v, bit m);
        cdb_valid      = 1'b1;
        cdb_tag        = TW'(t);
        cdb_value      = v;
        cdb_mispredict = m;
    endtask

    task automatic rand_cycle();
        int inc[$];
        int r, p, t;
        idle();
        disp($urandom_range(0, WIDTH), $urandom_range(0, 31));
        for (int i = 0; i < mq.size(); i++) if (!mq[i].done) inc.push_back(i);
        r = $urandom_range(0, 9);
        if (r < 7 && inc.size() > 0) begin
            p = inc[$urandom_range(0, inc.size() - 1)];
            cdb(mq[p].tag, $urandom, $urandom_range(0, 24) == 0);
        end else if (r == 7) begin
            t = $urandom_range(0, DEPTH - 1);
            if (m_find(TW'(t)) < 0) cdb(t, $urandom, 1'b1);
        end
        rd_tag_a = TW'($urandom_range(0, DEPTH - 1));
        rd_tag_b = TW'($urandom_range(0, DEPTH - 1));
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rd_tag_a = '0;
        rd_tag_b = '0;
        dp_dest_reg = '0;
        dp_pc = '0;
        step();
        step();
        @(negedge clock);
        chk("lit_rst_free", 64'(dp_free), 64'(2));
        chk("lit_rst_tag", 64'(dp_tag), 64'(8'h10));
        step();
        reset = 1'b0;

        // Fill: two lanes per cycle, tags 0..15
        for (int c = 0; c < 8; c++) begin
            disp(2, 2 * c);
            @(negedge clock);
            chk("lit_fill_tag", 64'(dp_tag), 64'({TW'(2 * c + 1), TW'(2 * c)}));
            step();
        end
        disp(2, 20);
        @(negedge clock);
        chk("lit_full_free", 64'(dp_free), 64'(0));
        chk("lit_full_count", 64'(count), 64'(16));
        step();
        idle();
        @(negedge clock);
        chk("lit_full_hold", 64'(count), 64'(16));
        step();

        // Out-of-order completion, in-order retire
        cdb(1, 32'h111, 1'b0);
        step();
        idle();
        @(negedge clock);
        chk("lit_no_early_retire", 64'(rt_valid), 64'(0));
        step();
        cdb(0, 32'h100, 1'b0);
        step();
        idle();
        @(negedge clock);
        chk("lit_rt_valid2", 64'(rt_valid), 64'(2'b11));
        chk("lit_rt_tag2", 64'(rt_tag), 64'(8'h10));
        chk("lit_rt_val0", 64'(rt_value[XLEN-1:0]), 64'(32'h100));
        chk("lit_rt_val1", 64'(rt_value[2*XLEN-1:XLEN]), 64'(32'h111));
        step();
        @(negedge clock);
        chk("lit_count14", 64'(count), 64'(14));
        step();

        // Wrap-around
        disp(2, 30);
        @(negedge clock);
        chk("lit_wrap_tag01", 64'(dp_tag), 64'(8'h10));
        step();
        idle();
        cdb(2, 32'h2, 1'b0);
        step();
        cdb(3, 32'h3, 1'b0);
        step();
        idle();
        step();
        disp(2, 40);
        @(negedge clock);
        chk("lit_wrap_tag23", 64'(dp_tag), 64'(8'h32));
        step();
        idle();
        @(negedge clock);
        chk("lit_wrap_count", 64'(count), 64'(16));
        step();

        // Mispredict at tag 5 with tag 6 complete behind it
        cdb(4, 32'h4, 1'b0);
        step();
        cdb(6, 32'h6, 1'b0);
        step();
        cdb(5, 32'h5, 1'b1);
        step();
        idle();
        disp(2, 50);
        cdb(7, 32'h777, 1'b0);
        @(negedge clock);
        chk("lit_mis_rt_valid", 64'(rt_valid), 64'(2'b01));
        chk("lit_mis_flush", 64'(flush), 64'(1));
        chk("lit_mis_tag", 64'(rt_tag[TW-1:0]), 64'(5));
        step();
        idle();
        @(negedge clock);
        chk("lit_flush_count", 64'(count), 64'(0));
        chk("lit_flush_tag", 64'(dp_tag), 64'(8'h10));
        step();

        // Operand read of a tag completing this cycle
        disp(2, 60);
        step();
        disp(2, 62);
        step();
        idle();
        cdb(3, 32'hDEADBEEF, 1'b0);
        rd_tag_a = TW'(3);
        @(negedge clock);
`ifdef ROB_CDB_BYPASS_EN
        chk("lit_byp_ready", 64'(rd_ready_a), 64'(1));
        chk("lit_byp_value", 64'(rd_value_a), 64'(32'hDEADBEEF));
`else
        chk("lit_nobyp_ready", 64'(rd_ready_a), 64'(0));
`endif
        step();
        idle();
        @(negedge clock);
        chk("lit_rd_ready_next", 64'(rd_ready_a), 64'(1));
        chk("lit_rd_value_next", 64'(rd_value_a), 64'(32'hDEADBEEF));
        step();

        for (int c = 0; c < 3000; c++) rand_cycle();

        // Reset with nine entries in flight and a CDB broadcast pending
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            disp(2, 70 + 2 * c);
            step();
        end
        disp(1, 80);
        step();
        idle();
        @(negedge clock);
        chk("lit_count9", 64'(count), 64'(9));
        step();
        reset = 1'b1;
        cdb(2, 32'hAB, 1'b0);
        step();
        reset = 1'b0;
        idle();
        @(negedge clock);
        chk("lit_rst_mid_count", 64'(count), 64'(0));
        chk("lit_rst_mid_rt_valid", 64'(rt_valid), 64'(0));
        chk("lit_rst_mid_free", 64'(dp_free), 64'(2));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
